// File: rtl/phase_step_sweep.sv
// phase_step_sweep: linear frequency-sweep controller feeding the 32-bit
// phase-step input of the quarter-wave sine generator.
// A sweep ramps o_phase_step from start_step to stop_step in steps of
// step_inc. There are dwell+1 cycles between updates.
// Optional feature macro: SWEEP_TRIANGLE_EN. When it is defined the block
// runs a continuous up/down triangle sweep until i_stop. When it is
// undefined the block does a single ramp that ends with o_done.
module phase_step_sweep #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [31:0]            i_start_step,
    input  logic [31:0]            i_stop_step,
    input  logic [31:0]            i_step_inc,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    output logic [31:0]            o_phase_step,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_dir
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
`ifdef SWEEP_TRIANGLE_EN
    localparam logic [1:0] ST_DOWN = 2'd2;
`endif

    logic [1:0]             state;
    logic [31:0]            stop_q;
    logic [31:0]            inc_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [31:0]            phase_q;
    logic                   busy_q;
    logic                   done_q;

    // 33-bit sum: a carry out of bit 31 means the true value is already
    // past any 32-bit stop_step, so the clamp absorbs it and nothing wraps.
    logic [32:0] up_sum;
    logic        up_hit;
    logic        dwell_hit;

    assign up_sum    = {1'b0, phase_q} + {1'b0, inc_q};
    assign up_hit    = (up_sum >= {1'b0, stop_q});
    assign dwell_hit = (dwell_cnt == dwell_q);

`ifdef SWEEP_TRIANGLE_EN
    // The start value is needed again only for the downward leg.
    logic [31:0] start_q;
    logic        dir_q;
    logic [32:0] dn_diff;
    logic        dn_hit;

    // Signed 33-bit compare so that an underflow below zero also hits.
    assign dn_diff = {1'b0, phase_q} - {1'b0, inc_q};
    assign dn_hit  = ($signed(dn_diff) <= $signed({1'b0, start_q}));
`endif

    // Sweep FSM, dwell counter and phase-step register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            stop_q    <= '0;
            inc_q     <= '0;
            dwell_q   <= '0;
            dwell_cnt <= '0;
            phase_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
            start_q   <= '0;
            dir_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A simultaneous stop wins over start.
                    if (i_start && !i_stop) begin
                        stop_q    <= i_stop_step;
                        inc_q     <= i_step_inc;
                        dwell_q   <= i_dwell;
                        dwell_cnt <= '0;
                        phase_q   <= i_start_step;
                        busy_q    <= 1'b1;
                        state     <= ST_UP;
`ifdef SWEEP_TRIANGLE_EN
                        start_q   <= i_start_step;
                        dir_q     <= 1'b0;
`endif
                    end
                end
                ST_UP: begin
                    if (i_stop) begin
                        // Abort: phase freezes, no completion pulse.
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (dwell_hit) begin
                        dwell_cnt <= '0;
                        if (up_hit) begin
                            phase_q <= stop_q;
`ifdef SWEEP_TRIANGLE_EN
                            dir_q   <= 1'b1;
                            state   <= ST_DOWN;
`else
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= ST_IDLE;
`endif
                        end else begin
                            phase_q <= up_sum[31:0];
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                    end
                end
`ifdef SWEEP_TRIANGLE_EN
                ST_DOWN: begin
                    if (i_stop) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        dir_q  <= 1'b0;
                    end else if (dwell_hit) begin
                        dwell_cnt <= '0;
                        if (dn_hit) begin
                            // One full triangle period completed.
                            phase_q <= start_q;
                            dir_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= ST_UP;
                        end else begin
                            phase_q <= dn_diff[31:0];
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                    end
                end
`endif
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_phase_step = phase_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
`ifdef SWEEP_TRIANGLE_EN
    assign o_dir        = dir_q;
`else
    assign o_dir        = 1'b0;
`endif

endmodule

// File: tb/tb_phase_step_sweep.sv
// Directed testbench for phase_step_sweep. It uses hand-computed expected
// values. The triangle-sweep section is built only with SWEEP_TRIANGLE_EN.
module tb_phase_step_sweep;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic        i_stop;
    logic [31:0] i_start_step;
    logic [31:0] i_stop_step;
    logic [31:0] i_step_inc;
    logic [15:0] i_dwell;
    logic [31:0] o_phase_step;
    logic        o_busy;
    logic        o_done;
    logic        o_dir;

    int vectors = 0;
    int miscompares = 0;

    phase_step_sweep #(.DWELL_WIDTH(16)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_start_step (i_start_step),
        .i_stop_step  (i_stop_step),
        .i_step_inc   (i_step_inc),
        .i_dwell      (i_dwell),
        .o_phase_step (o_phase_step),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_dir        (o_dir)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Expected phase/done/busy on each edge after loading 100..130, inc 10, dwell 2.
    logic [31:0] ramp_ph   [10] = '{100, 100, 110, 110, 110, 120, 120, 120, 130, 130};
    logic        ramp_done [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic        ramp_busy [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ph, input logic b,
                           input logic d, input logic dr);
        chk({tag, ".phase"}, o_phase_step, ph);
        chk({tag, ".busy"},  {31'd0, o_busy}, {31'd0, b});
        chk({tag, ".done"},  {31'd0, o_done}, {31'd0, d});
        chk({tag, ".dir"},   {31'd0, o_dir},  {31'd0, dr});
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] inc, input logic [15:0] dw);
        i_start_step = a;
        i_stop_step  = b;
        i_step_inc   = inc;
        i_dwell      = dw;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0;
        i_start_step = '0; i_stop_step = '0; i_step_inc = '0; i_dwell = '0;
        #3;
        chk_all("in_reset", 32'd0, 1'b0, 1'b0, 1'b0);
        #9;
        i_rst_n = 1'b1;

        // Idle after reset release.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("idle", 32'd0, 1'b0, 1'b0, 1'b0);
        end

        // Single ramp 100 -> 130, inc 10, dwell 2.
        load(32'd100, 32'd130, 32'd10, 16'd2);
        chk_all("ramp_load", 32'd100, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ramp.phase", o_phase_step, ramp_ph[i]);
            chk("ramp.done",  {31'd0, o_done}, {31'd0, ramp_done[i]});
            chk("ramp.busy",  {31'd0, o_busy}, {31'd0, ramp_busy[i]});
        end

        // Top-of-range clamp: the sum carries out of 32 bits and must not wrap.
        load(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0);
        chk_all("top_load", 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("top_clamp", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("top_after", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Abort at 110. A start while busy is ignored.
        load(32'd100, 32'd130, 32'd10, 16'd2);
        i_start = 1'b1; i_start_step = 32'd999;
        tick();
        i_start = 1'b0;
        chk("busy_ignore_start", o_phase_step, 32'd100);
        tick(); tick();
        chk_all("pre_abort", 32'd110, 1'b1, 1'b0, 1'b0);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk_all("abort", 32'd110, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("abort_hold", 32'd110, 1'b0, 1'b0, 1'b0);
        load(32'd40, 32'd50, 32'd5, 16'd0);
        chk_all("restart", 32'd40, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("restart_upd", 32'd45, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("restart_end", 32'd50, 1'b0, 1'b1, 1'b0);

        // A zero increment holds start_step until stopped.
        load(32'd50, 32'd60, 32'd0, 16'd0);
        for (int i = 0; i < 5; i++) tick();
        chk_all("inc0_hold", 32'd50, 1'b1, 1'b0, 1'b0);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk_all("inc0_stop", 32'd50, 1'b0, 1'b0, 1'b0);

        // Degenerate start >= stop: the first update clamps to stop.
        load(32'd200, 32'd150, 32'd1, 16'd1);
        chk_all("degen_load", 32'd200, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("degen_dwell", 32'd200, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("degen_clamp", 32'd150, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-sweep, checked between clock edges.
        load(32'd100, 32'd130, 32'd10, 16'd0);
        tick();
        chk("pre_rst.phase", o_phase_step, 32'd110);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all("async_rst", 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        i_rst_n = 1'b1;

        // A start and a stop together in IDLE: stop wins.
        i_start_step = 32'd77; i_start = 1'b1; i_stop = 1'b1;
        tick();
        i_start = 1'b0; i_stop = 1'b0;
        chk_all("start_and_stop", 32'd0, 1'b0, 1'b0, 1'b0);

`ifdef SWEEP_TRIANGLE_EN
        // Triangle sweep 0..20, inc 10, dwell 0.
        load(32'd0, 32'd20, 32'd10, 16'd0);
        chk_all("tri0", 32'd0, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("tri1", 32'd10, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("tri2", 32'd20, 1'b1, 1'b0, 1'b1);
        tick(); chk_all("tri3", 32'd10, 1'b1, 1'b0, 1'b1);
        tick(); chk_all("tri4", 32'd0,  1'b1, 1'b1, 1'b0);
        tick(); chk_all("tri5", 32'd10, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("tri6", 32'd20, 1'b1, 1'b0, 1'b1);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk_all("tri_stop", 32'd20, 1'b0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
